ship_core_n: RTL

SHIP_CORE_N -- requirements
Module: ship_core_n

---
 rtl/ship_core_n_pkg.sv | 15 +
 rtl/ship_core_n_hitbox.sv | 29 ++
 rtl/ship_core_n.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ship_core_n_pkg.sv
// Shared game definitions: ship state encoding and the packed coordinate slice width.
package ship_core_n_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_HIT       = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } ship_state_t;

endpackage

// File: rtl/ship_core_n_hitbox.sv
// Single-channel test: is one enemy missile inside the ship's rectangular hitbox?
module ship_hitbox_cmp
    import ship_core_n_pkg::*;
#(
    parameter int SHIP_W = 64,
    parameter int SHIP_H = 48,
    parameter int SHIP_Y = 680
) (
    input  logic   en_on,
    input  coord_t en_x,
    input  coord_t en_y,
    input  coord_t xpos,
    output logic   hit
);

    localparam logic [COORD_W:0] SW = (COORD_W + 1)'(SHIP_W);
    localparam logic [COORD_W:0] SH = (COORD_W + 1)'(SHIP_H);
    localparam logic [COORD_W:0] SY = (COORD_W + 1)'(SHIP_Y);

    // One extra bit so the right/bottom edges cannot wrap near the screen limit.
    logic [COORD_W:0] ex, ey, xl;

    assign ex = {1'b0, en_x};
    assign ey = {1'b0, en_y};
    assign xl = {1'b0, xpos};

    assign hit = en_on && (ex >= xl) && (ex < xl + SW) && (ey >= SY) && (ey < SY + SH);

endmodule

// File: rtl/ship_core_n.sv
// Player ship: movement, collision/lives FSM with explosion and invulnerability, and a single player missile.
module ship_core_n
    import ship_core_n_pkg::*;
#(
    parameter int N_EN          = 5,
    parameter int SHIP_W        = 64,
    parameter int SHIP_H        = 48,
    parameter int SHIP_Y        = 680,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 960,
    parameter int SPEED         = 4,
    parameter int LIVES         = 3,
    parameter int HIT_FRAMES    = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int COOLDOWN      = 15,
    parameter int MSL_SPEED     = 8,
    localparam int LW           = $clog2(LIVES + 1)
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    left,
    input  logic                    right,
    input  logic                    fire,
    input  logic                    restart,
    input  logic [COORD_W*N_EN-1:0] en_x,
    input  logic [COORD_W*N_EN-1:0] en_y,
    input  logic [N_EN-1:0]         en_on,
    output coord_t                  xpos_ship,
    output logic                    ship_visible,
    output logic                    ship_exploding,
    output coord_t                  missile_x,
    output coord_t                  missile_y,
    output logic                    missile_on,
    output logic                    ship_hit,
    output logic [LW-1:0]           lives,
    output logic                    game_over,
    output ship_state_t             state
);

    localparam int T_MAX = (HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int CW    = $clog2(COOLDOWN + 1);

    localparam coord_t          X_MID      = coord_t'((X_MIN + X_MAX) / 2);
    localparam coord_t          X_LO       = coord_t'(X_MIN);
    localparam coord_t          X_HI       = coord_t'(X_MAX);
    localparam coord_t          SPD        = coord_t'(SPEED);
    localparam coord_t          MSL_OFS    = coord_t'(SHIP_W / 2);
    localparam coord_t          MSL_Y0     = coord_t'(SHIP_Y - 1);
    localparam coord_t          MSPD       = coord_t'(MSL_SPEED);
    localparam logic [LW-1:0]   LIVES_INIT = LW'(LIVES);
    localparam logic [LW-1:0]   LAST_LIFE  = LW'(1);
    localparam logic [TW-1:0]   T_HIT_LAST = TW'(HIT_FRAMES - 1);
    localparam logic [TW-1:0]   T_HIT_END  = TW'(HIT_FRAMES);
    localparam logic [TW-1:0]   T_INV_LAST = TW'(INVULN_FRAMES - 1);
    localparam logic [CW-1:0]   CD_LOAD    = CW'(COOLDOWN);

    logic [N_EN-1:0] ch_hit;
    logic            coll_q;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_inc;
    logic [CW-1:0]   cooldown;
    logic            fire_q;
    logic            launch;
    logic            can_act;
    coord_t          xpos_move;

    for (genvar i = 0; i < N_EN; i++) begin : g_ch
        ship_hitbox_cmp #(
            .SHIP_W (SHIP_W),
            .SHIP_H (SHIP_H),
            .SHIP_Y (SHIP_Y)
        ) u_cmp (
            .en_on (en_on[i]),
            .en_x  (en_x[COORD_W*i +: COORD_W]),
            .en_y  (en_y[COORD_W*i +: COORD_W]),
            .xpos  (xpos_ship),
            .hit   (ch_hit[i])
        );
    end

    assign timer_inc = timer + 1'b1;
    assign can_act   = (state == ST_ALIVE) || (state == ST_INVULN);
    assign launch    = fire && !fire_q && can_act && !missile_on && (cooldown == '0);

    // Clamp in signed int arithmetic so a step past either bound never wraps.
    always_comb begin
        xpos_move = xpos_ship;
        if (left && !right) begin
            xpos_move = (int'(xpos_ship) - SPEED < X_MIN) ? X_LO : xpos_ship - SPD;
        end else if (right && !left) begin
            xpos_move = (int'(xpos_ship) + SPEED > X_MAX) ? X_HI : xpos_ship + SPD;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state          <= ST_ALIVE;
            xpos_ship      <= X_MID;
            lives          <= LIVES_INIT;
            timer          <= '0;
            coll_q         <= 1'b0;
            ship_hit       <= 1'b0;
            ship_visible   <= 1'b1;
            ship_exploding <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            coll_q   <= |ch_hit;
            ship_hit <= 1'b0;
            if (frame_tick && can_act) begin
                xpos_ship <= xpos_move;
            end
            case (state)
                ST_ALIVE: begin
                    if (coll_q) begin
                        ship_hit       <= 1'b1;
                        lives          <= lives - 1'b1;
                        timer          <= '0;
                        ship_visible   <= 1'b0;
                        ship_exploding <= 1'b1;
                        if (lives == LAST_LIFE) begin
                            state     <= ST_GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= ST_HIT;
                        end
                    end
                end
                ST_HIT: begin
                    if (frame_tick) begin
                        if (timer == T_HIT_LAST) begin
                            state          <= ST_INVULN;
                            timer          <= '0;
                            xpos_ship      <= X_MID;
                            ship_exploding <= 1'b0;
                            ship_visible   <= 1'b0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                ST_INVULN: begin
                    // Blink follows bit 3 of the frames spent invulnerable.
                    if (frame_tick) begin
                        if (timer == T_INV_LAST) begin
                            state        <= ST_ALIVE;
                            timer        <= '0;
                            ship_visible <= 1'b1;
                        end else begin
                            timer        <= timer_inc;
                            ship_visible <= timer_inc[3];
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (restart) begin
                        state          <= ST_ALIVE;
                        lives          <= LIVES_INIT;
                        xpos_ship      <= X_MID;
                        timer          <= '0;
                        ship_visible   <= 1'b1;
                        ship_exploding <= 1'b0;
                        game_over      <= 1'b0;
                    end else if (frame_tick && timer != T_HIT_END) begin
                        timer          <= timer_inc;
                        ship_exploding <= (timer_inc < T_HIT_END);
                    end
                end
                default: state <= ST_ALIVE;
            endcase
        end
    end

    // The player missile keeps flying whatever happens to the ship.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            fire_q     <= 1'b0;
            missile_on <= 1'b0;
            missile_x  <= '0;
            missile_y  <= '0;
            cooldown   <= '0;
        end else begin
            fire_q <= fire;
            if (launch) begin
                missile_on <= 1'b1;
                missile_x  <= xpos_ship + MSL_OFS;
                missile_y  <= MSL_Y0;
                cooldown   <= CD_LOAD;
            end else begin
                if (frame_tick && cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end
                if (frame_tick && missile_on) begin
                    if (missile_y < MSPD) begin
                        missile_on <= 1'b0;
                    end else begin
                        missile_y <= missile_y - MSPD;
                    end
                end
            end
        end
    end

endmodule
